// File: rtl/next_pc_unit_pkg.sv
// Shared datapath definitions for the PC / next-PC stage:
// next-PC select encodings, reset and exception addresses, FSM states.
package next_pc_unit_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [2:0] {
    NPC_SEQ    = 3'b000,
    NPC_BEQ    = 3'b001,
    NPC_BGEZAL = 3'b010,
    NPC_J      = 3'b011,
    NPC_JR     = 3'b100,
    NPC_ERET   = 3'b101
  } npc_sel_e;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, jump and register jump.
// All additions wrap modulo 2^32.
module npc_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  output logic [31:0] seq,
  output logic [31:0] br,
  output logic [31:0] jmp,
  output logic [31:0] jr
);

  assign seq = pc + 32'd4;
  assign br  = seq + {{14{imm16[15]}}, imm16, 2'b00};
  assign jmp = {seq[31:28], instr_index, 2'b00};
  // Register targets are forced word-aligned.
  assign jr  = rs_data & 32'hFFFF_FFFC;

endmodule

// File: rtl/next_pc_unit.sv
// PC register, EPC register, run-state FSM and prioritised next-PC mux.
//   state  | meaning
//   S_BOOT | one cycle after reset, pc held, no fetch
//   S_RUN  | fetching; pc advances per npc_sel / trap / stall
//   S_HALT | fetch stopped, pc frozen until reset
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = next_pc_unit_pkg::PC_RESET,
  parameter logic [31:0] EXC_VECTOR = next_pc_unit_pkg::EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  npc_sel,
  input  logic        zero,
  input  logic        condition_jdg,
  input  logic        overflow,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_data,
  input  logic        stall,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        branch_taken,
  output logic        wb_kill,
  output logic [31:0] epc,
  output logic        exc_pulse,
  output logic        fetch_valid,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        exc_pulse_q, exc_pulse_d;
  logic [31:0] tgt_seq, tgt_br, tgt_jmp, tgt_jr;

  npc_target_calc u_target_calc (
    .pc          (pc_q),
    .imm16       (imm16),
    .instr_index (instr_index),
    .rs_data     (rs_data),
    .seq         (tgt_seq),
    .br          (tgt_br),
    .jmp         (tgt_jmp),
    .jr          (tgt_jr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      pc_q        <= PC_RESET;
      epc_q       <= '0;
      exc_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      exc_pulse_q <= exc_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epc_d        = epc_q;
    exc_pulse_d  = 1'b0;
    branch_taken = 1'b0;
    wb_kill      = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (overflow) begin
          // Trap beats every other redirect, including ERET.
          pc_d        = EXC_VECTOR;
          epc_d       = pc_q;
          exc_pulse_d = 1'b1;
          wb_kill     = 1'b1;
        end else if (halt) begin
          state_d = S_HALT;
        end else begin
          pc_d = tgt_seq;
          case (npc_sel)
            NPC_BEQ: begin
              if (zero) begin
                pc_d         = tgt_br;
                branch_taken = 1'b1;
              end
            end
            NPC_BGEZAL: begin
              if (condition_jdg) begin
                pc_d         = tgt_br;
                branch_taken = 1'b1;
              end
            end
            NPC_J: begin
              pc_d         = tgt_jmp;
              branch_taken = 1'b1;
            end
            NPC_JR: begin
              pc_d         = tgt_jr;
              branch_taken = 1'b1;
            end
            NPC_ERET: begin
              pc_d         = epc_q;
              branch_taken = 1'b1;
            end
            default: pc_d = tgt_seq;
          endcase
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  assign pc          = pc_q;
  assign pc_plus4    = tgt_seq;
  assign epc         = epc_q;
  assign exc_pulse   = exc_pulse_q;
  assign fetch_valid = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: stimulus pushes expected observations into
// a scoreboard queue, a monitor drains and compares them mid-cycle.
module tb_next_pc_unit;

  localparam int SIG_PC    = 0;
  localparam int SIG_PC4   = 1;
  localparam int SIG_TAKEN = 2;
  localparam int SIG_KILL  = 3;
  localparam int SIG_EPC   = 4;
  localparam int SIG_EXC   = 5;
  localparam int SIG_FV    = 6;
  localparam int SIG_HALT  = 7;

  localparam logic [2:0] SEQ = 3'b000, BEQ = 3'b001, BGZ = 3'b010,
                         JMP = 3'b011, JR = 3'b100, ERET = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  npc_sel;
  logic        zero, condition_jdg, overflow, stall, halt;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_data;
  logic [31:0] pc, pc_plus4, epc;
  logic        branch_taken, wb_kill, exc_pulse, fetch_valid, halted;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  next_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .npc_sel       (npc_sel),
    .zero          (zero),
    .condition_jdg (condition_jdg),
    .overflow      (overflow),
    .imm16         (imm16),
    .instr_index   (instr_index),
    .rs_data       (rs_data),
    .stall         (stall),
    .halt          (halt),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .wb_kill       (wb_kill),
    .epc           (epc),
    .exc_pulse     (exc_pulse),
    .fetch_valid   (fetch_valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] sel, input logic z, input logic cj,
                       input logic ov, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs,
                       input logic st, input logic hl);
    npc_sel = sel; zero = z; condition_jdg = cj; overflow = ov;
    imm16 = imm; instr_index = idx; rs_data = rs; stall = st; halt = hl;
  endtask

  task automatic expect_sig(input string nm, input int sig, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sig  = sig;
    c.exp  = v;
    sb.push_back(c);
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_PC:    return pc;
      SIG_PC4:   return pc_plus4;
      SIG_TAKEN: return {31'd0, branch_taken};
      SIG_KILL:  return {31'd0, wb_kill};
      SIG_EPC:   return epc;
      SIG_EXC:   return {31'd0, exc_pulse};
      SIG_FV:    return {31'd0, fetch_valid};
      SIG_HALT:  return {31'd0, halted};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: observations are taken 2 time units after the falling edge.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        c   = sb.pop_front();
        act = observe(c.sig);
        n_checks++;
        if (act === c.exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    drive(SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    repeat (3) @(negedge clk);

    // Release reset: BOOT cycle
    @(negedge clk); reset = 1'b0;
    expect_sig("boot_pc", SIG_PC, 32'h3000);
    expect_sig("boot_fv", SIG_FV, 0);
    expect_sig("boot_halted", SIG_HALT, 0);
    expect_sig("boot_epc", SIG_EPC, 0);
    expect_sig("boot_exc", SIG_EXC, 0);
    @(negedge clk);
    expect_sig("run_fv", SIG_FV, 1);
    expect_sig("run_pc", SIG_PC, 32'h3000);
    @(negedge clk); expect_sig("seq1_pc", SIG_PC, 32'h3004);
    @(negedge clk); expect_sig("seq2_pc", SIG_PC, 32'h3008);
    expect_sig("seq2_pc4", SIG_PC4, 32'h300C);
    @(negedge clk); expect_sig("seq3_pc", SIG_PC, 32'h300C);

    // BEQ backwards to itself, then not taken
    @(negedge clk); drive(BEQ, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0, 0);
    expect_sig("beq_t_pc", SIG_PC, 32'h3010);
    expect_sig("beq_t_taken", SIG_TAKEN, 1);
    @(negedge clk); drive(BEQ, 0, 0, 0, 16'hFFFF, 26'h0, 32'h0, 0, 0);
    expect_sig("beq_t_next", SIG_PC, 32'h3010);
    expect_sig("beq_nt_taken", SIG_TAKEN, 0);
    @(negedge clk); drive(JMP, 0, 0, 0, 16'h0, 26'h0000C08, 32'h0, 0, 0);
    expect_sig("beq_nt_next", SIG_PC, 32'h3014);
    expect_sig("j_taken", SIG_TAKEN, 1);

    // BGEZAL taken / not taken
    @(negedge clk); drive(BGZ, 0, 1, 0, 16'h0004, 26'h0, 32'h0, 0, 0);
    expect_sig("j_next", SIG_PC, 32'h3020);
    expect_sig("bgz_link", SIG_PC4, 32'h3024);
    expect_sig("bgz_t_taken", SIG_TAKEN, 1);
    @(negedge clk); drive(JR, 0, 0, 0, 16'h0, 26'h0, 32'h0000_3020, 0, 0);
    expect_sig("bgz_t_next", SIG_PC, 32'h3034);
    @(negedge clk); drive(BGZ, 0, 0, 0, 16'h0004, 26'h0, 32'h0, 0, 0);
    expect_sig("jr_back", SIG_PC, 32'h3020);
    expect_sig("bgz_nt_taken", SIG_TAKEN, 0);
    @(negedge clk); drive(JMP, 0, 0, 0, 16'h0, 26'h0000C10, 32'h0, 0, 0);
    expect_sig("bgz_nt_next", SIG_PC, 32'h3024);

    // J to 0x3040 (self), then JR with unaligned register
    @(negedge clk); drive(JMP, 0, 0, 0, 16'h0, 26'h0000C10, 32'h0, 0, 0);
    expect_sig("j_pc", SIG_PC, 32'h3040);
    @(negedge clk); drive(JR, 0, 0, 0, 16'h0, 26'h0, 32'h0000_3107, 0, 0);
    expect_sig("j_self", SIG_PC, 32'h3040);
    expect_sig("jr_taken", SIG_TAKEN, 1);
    @(negedge clk); drive(JR, 0, 0, 0, 16'h0, 26'h0, 32'h0000_3050, 0, 0);
    expect_sig("jr_align", SIG_PC, 32'h3104);

    // Overflow trap with ERET requested in the same cycle
    @(negedge clk); drive(ERET, 0, 0, 1, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("ovf_pc", SIG_PC, 32'h3050);
    expect_sig("ovf_kill", SIG_KILL, 1);
    expect_sig("ovf_taken", SIG_TAKEN, 0);
    expect_sig("ovf_exc_pre", SIG_EXC, 0);
    // Stall with overflow: everything holds
    @(negedge clk); drive(SEQ, 0, 0, 1, 16'h0, 26'h0, 32'h0, 1, 0);
    expect_sig("trap_pc", SIG_PC, 32'h4180);
    expect_sig("trap_epc", SIG_EPC, 32'h3050);
    expect_sig("trap_exc", SIG_EXC, 1);
    expect_sig("stall_kill", SIG_KILL, 0);
    expect_sig("stall_taken", SIG_TAKEN, 0);
    @(negedge clk); drive(ERET, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("stall_pc", SIG_PC, 32'h4180);
    expect_sig("stall_epc", SIG_EPC, 32'h3050);
    expect_sig("exc_one_cycle", SIG_EXC, 0);
    expect_sig("eret_taken", SIG_TAKEN, 1);

    // Back-to-back overflows
    @(negedge clk); drive(SEQ, 0, 0, 1, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("eret_pc", SIG_PC, 32'h3050);
    @(negedge clk); drive(SEQ, 0, 0, 1, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("b2b1_pc", SIG_PC, 32'h4180);
    expect_sig("b2b1_epc", SIG_EPC, 32'h3050);
    expect_sig("b2b2_kill", SIG_KILL, 1);
    @(negedge clk); drive(3'b110, 1, 1, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("b2b2_pc", SIG_PC, 32'h4180);
    expect_sig("b2b2_epc", SIG_EPC, 32'h4180);
    expect_sig("b2b2_exc", SIG_EXC, 1);
    expect_sig("undef_taken", SIG_TAKEN, 0);

    // Halt: stall wins first, then HALT absorbs
    @(negedge clk); drive(SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1, 1);
    expect_sig("undef_next", SIG_PC, 32'h4184);
    expect_sig("undef_exc", SIG_EXC, 0);
    @(negedge clk); drive(JMP, 0, 0, 0, 16'h0, 26'h0000C10, 32'h0, 0, 1);
    expect_sig("stall_halt_pc", SIG_PC, 32'h4184);
    expect_sig("stall_halt_st", SIG_HALT, 0);
    expect_sig("halt_taken", SIG_TAKEN, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(JMP, 0, 0, 1, 16'h0, 26'h0000C10, 32'h0, 0, 0);
      expect_sig("halt_pc", SIG_PC, 32'h4184);
      expect_sig("halt_flag", SIG_HALT, 1);
      expect_sig("halt_fv", SIG_FV, 0);
      expect_sig("halt_kill", SIG_KILL, 0);
    end

    // Reset during HALT
    @(negedge clk); reset = 1'b1; drive(SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    @(negedge clk); reset = 1'b0;
    expect_sig("rst_pc", SIG_PC, 32'h3000);
    expect_sig("rst_halted", SIG_HALT, 0);
    expect_sig("rst_fv", SIG_FV, 0);
    expect_sig("rst_epc", SIG_EPC, 0);
    @(negedge clk); drive(JR, 0, 0, 0, 16'h0, 26'h0, 32'hFFFF_FFFF, 0, 0);
    expect_sig("rst_run_fv", SIG_FV, 1);

    // Address wrap
    @(negedge clk); drive(BEQ, 1, 0, 0, 16'h0001, 26'h0, 32'h0, 0, 0);
    expect_sig("wrap_pc", SIG_PC, 32'hFFFF_FFFC);
    expect_sig("wrap_pc4", SIG_PC4, 32'h0000_0000);
    @(negedge clk); drive(SEQ, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0, 0);
    expect_sig("wrap_br", SIG_PC, 32'h0000_0004);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #5;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d observations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
